dl_onehot_dec_hs: RTL
=====================

// Module: dl_onehot_dec_hs
// PURPOSE
//   Handshaked index-to-one-hot decoder; the inverse of the priority-encoder path.
//   Accepts a binary index over a valid/ready interface and drives the matching one-hot select line.
//   Holds that line until the selected target acknowledges it, or until a timeout expires.
//   Sits between arbitration/encode logic and per-target select lines.
//   A 1-entry holding register allows back-to-back selects.
// PARAMETERS
//   OUTPUT_WIDTH  4    number of one-hot select lines (>=2)
//   INPUT_WIDTH   $clog2(OUTPUT_WIDTH)  index width (localparam)
//   TIMEOUT       16   cycles to wait for ack before abort; 0 = never time out
//   TO_W          $clog2(TIMEOUT+1)  timeout counter width (localparam)
// PORTS
//   clk          in   1             clock, rising edge
//   rst          in   1             asynchronous reset, active-high
//   in_valid     in   1             index valid
//   in_ready     out  1             block can accept index
//   in_idx       in   INPUT_WIDTH   binary index of line to select
//   out_onehot   out  OUTPUT_WIDTH  registered one-hot select, at most one bit set
//   out_ack      in   OUTPUT_WIDTH  per-line acknowledge from targets
//   busy         out  1             select active or holding register occupied
//   err_range    out  1             1-cycle pulse: accepted index >= OUTPUT_WIDTH, dropped
//   err_timeout  out  1             1-cycle pulse: select aborted on timeout
//   err_stray    out  1             1-cycle pulse: ack on a line that is not selected
// BEHAVIOUR
//   Reset (async, immediate): out_onehot=0, pending register empty, FSM=IDLE, timeout counter=0.
//     err_* = 0; in_ready = 1 once rst deasserts; busy = 0.
//   Handshake: transfer when in_valid & in_ready at a rising edge.
//     in_ready = !pend_valid (registered state only); it does not depend combinationally on out_ack.
//     in_idx is sampled only on a transfer.
//   Storage: 1-entry pending register plus the active select.
//     Transfer in IDLE -> index loads directly into active; out_onehot = 1<<idx from the next cycle (latency 1).
//     Transfer in DRIVE -> index loads into the pending register.
//   FSM: IDLE, DRIVE.
//     IDLE -> DRIVE: on transfer of an in-range index.
//     DRIVE, out_ack[sel]=1 -> select completes. If pending valid, the next cycle drives the pending index
//       (no idle gap) and pending clears. Otherwise out_onehot=0 next cycle and FSM -> IDLE.
//     DRIVE, counter reaches TIMEOUT-1 with no ack -> err_timeout pulses next cycle; same completion
//       rules as ack (pending advances or IDLE).
//   Timeout counter: cleared on entry to DRIVE and on every new select; +1 per DRIVE cycle without ack.
//     Saturates; inactive when TIMEOUT=0.
//   Range: an index >= OUTPUT_WIDTH is still accepted (handshake completes) but never driven.
//     err_range pulses the cycle after the transfer; FSM/pending state unchanged.
//   Ack rules:
//     Any out_ack bit set outside the selected line (or any ack in IDLE) -> err_stray pulses next cycle.
//       Such an ack does not complete the select.
//     Selected-line ack plus stray bits in the same cycle -> completes and also flags err_stray.
//   Simultaneous events:
//     Ack and transfer in the same cycle with pending empty -> new index goes to pending, then is
//       promoted immediately; net effect is back-to-back select.
//     Ack and timeout in the same cycle -> ack wins, no err_timeout.
//   busy = (FSM==DRIVE) | pend_valid.
//   Reset mid-DRIVE: select dropped immediately, pending lost, no error pulses.
// TESTING
//   1. Single select: idx=2, ack line 2 after 3 cycles -> out_onehot=4'b0100 for cycles 1..4;
//      0 after the ack cycle; busy falls.
//   2. Back-to-back: idx=1 then idx=3 while driving, ack line 1 -> 4'b0010 then 4'b1000 with no zero gap;
//      in_ready=0 while pending is full.
//   3. Timeout: TIMEOUT=16, idx=0, no ack -> 4'b0001 for 16 cycles, then err_timeout one-cycle pulse,
//      out_onehot=0, IDLE.
//   4. Stray ack: driving 4'b0100, out_ack=4'b0001 -> err_stray pulse, select held;
//      later out_ack=4'b0100 completes it.
//   5. Range (OUTPUT_WIDTH=3): idx=3 -> handshake completes, err_range pulse, out_onehot stays 0.
//   6. Async reset mid-DRIVE with pending full -> out_onehot=0 and busy=0 before the next clock edge;
//      in_ready=1 after release.

Source files
------------

// File: rtl/dl_onehot_dec_hs.sv
// rtl/dl_onehot_dec_hs.sv - handshaked index-to-one-hot select decoder
// One active select plus a 1-entry pending index; select ends on ack or timeout.
module dl_onehot_dec_hs #(
    parameter int OUTPUT_WIDTH = 4,
    parameter int TIMEOUT = 16,
    localparam int INPUT_WIDTH = $clog2(OUTPUT_WIDTH),
    localparam int TO_W = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  in_idx,
    output logic [OUTPUT_WIDTH-1:0] out_onehot,
    input  logic [OUTPUT_WIDTH-1:0] out_ack,
    output logic                    busy,
    output logic                    err_range,
    output logic                    err_timeout,
    output logic                    err_stray
);

    // TIMEOUT=0 would give a zero-width counter; keep one bit that never moves.
    localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t                   state_q, state_d;
    logic [OUTPUT_WIDTH-1:0]  onehot_d;
    logic                     pend_valid_q, pend_valid_d;
    logic [INPUT_WIDTH-1:0]   pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_range_d, err_timeout_d, err_stray_d;
    logic                     xfer, idx_ok, sel_ack, timeout_hit;

    function automatic logic [OUTPUT_WIDTH-1:0] onehot_of(input logic [INPUT_WIDTH-1:0] idx);
        return OUTPUT_WIDTH'(1) << idx;
    endfunction

    assign in_ready = !pend_valid_q;
    assign busy     = (state_q == DRIVE) | pend_valid_q;

    always_comb begin
        state_d       = state_q;
        onehot_d      = out_onehot;
        pend_valid_d  = pend_valid_q;
        pend_idx_d    = pend_idx_q;
        cnt_d         = cnt_q;
        err_timeout_d = 1'b0;

        xfer        = in_valid & !pend_valid_q;
        idx_ok      = {1'b0, in_idx} < (INPUT_WIDTH + 1)'(OUTPUT_WIDTH);
        sel_ack     = |(out_ack & out_onehot);
        // out_onehot is zero in IDLE, so this also flags every ack seen while idle.
        err_stray_d = |(out_ack & ~out_onehot);
        err_range_d = xfer & !idx_ok;
        timeout_hit = (TIMEOUT != 0) && (state_q == DRIVE) && !sel_ack
                      && (cnt_q == CNT_W'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (xfer && idx_ok) begin
                    state_d  = DRIVE;
                    onehot_d = onehot_of(in_idx);
                    cnt_d    = '0;
                end
            end
            DRIVE: begin
                if (sel_ack || timeout_hit) begin
                    err_timeout_d = timeout_hit;
                    cnt_d         = '0;
                    if (pend_valid_q) begin
                        onehot_d     = onehot_of(pend_idx_q);
                        pend_valid_d = 1'b0;
                    end else if (xfer && idx_ok) begin
                        // Index arriving on the completion cycle is promoted straight away.
                        onehot_d = onehot_of(in_idx);
                    end else begin
                        onehot_d = '0;
                        state_d  = IDLE;
                    end
                end else begin
                    if (TIMEOUT != 0 && cnt_q != {CNT_W{1'b1}})
                        cnt_d = cnt_q + CNT_W'(1);
                    if (xfer && idx_ok) begin
                        pend_valid_d = 1'b1;
                        pend_idx_d   = in_idx;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            out_onehot   <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            cnt_q        <= '0;
            err_range    <= 1'b0;
            err_timeout  <= 1'b0;
            err_stray    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_onehot   <= onehot_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            cnt_q        <= cnt_d;
            err_range    <= err_range_d;
            err_timeout  <= err_timeout_d;
            err_stray    <= err_stray_d;
        end
    end

endmodule
